fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch controller that owns the program counter and sequences instruction-memory accesses for the 60-bit core. Each access fetches one 120-bit bundle (two 60-bit instructions) at a bit address. The block resolves redirect sources (trap, jump, branch) into the next PC and runs a request/grant/response handshake toward instruction memory. Fetched bundles go to decode over a valid/ready interface, and wrong-path responses are squashed.

## Interface
- PC_W, 72, program counter width (bit address)
- BUNDLE_W, 120, fetch bundle width; also the sequential PC increment
- RESET_VECTOR, 0, PC loaded on reset
- TRAP_VECTOR, 72'h100, PC loaded on trap
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- trap_en  in  1  trap redirect request
- jump_en  in  1  jump redirect request
- jump_address  in  55  jump target, zero-extended to PC_W
- branch_en  in  1  taken-branch redirect request
- branch_address  in  68  branch target, zero-extended to PC_W
- imem_req  out  1  memory request
- imem_addr  out  72  request address (current pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  120  response bundle
- fetch_valid  out  1  bundle available to decode
- fetch_ready  in  1  decode accepts bundle
- fetch_bundle  out  120  registered bundle
- fetch_pc  out  72  address the bundle was fetched from

## Operation
- Registers: pc, state, squash flag, bundle register, bundle pc.
- Redirect target uses fixed priority trap > jump > branch. A redirect is any of the three enables being high. Enables are single-cycle pulses, sampled every cycle in every state except IDLE.
- States:
  - IDLE: entered on reset. Moves to REQ on the first clock edge after reset deasserts. Redirects are ignored.
  - REQ: imem_req=1, imem_addr=pc.
    - imem_gnt=1 → WAIT. If a redirect is present in the same cycle, pc<=target and squash<=1.
    - imem_gnt=0 with a redirect → stay in REQ, pc<=target. imem_addr changes the next cycle; memory tolerates a changing address while ungranted.
  - WAIT: imem_req=0. A redirect sets pc<=target and squash<=1.
    - imem_rvalid=1 with squash=1 (or a redirect this cycle) → discard data, squash<=0, go to REQ.
    - imem_rvalid=1 otherwise → bundle<=imem_rdata, bundle pc<=pc, go to OUT.
  - OUT: fetch_valid=1.
    - fetch_ready=1 → pc<=pc+BUNDLE_W, or the redirect target if a redirect is present; go to REQ.
    - Redirect without ready → fetch_valid drops the next cycle, pc<=target, go to REQ. The bundle is dropped.
- A handshake and a redirect in the same cycle: the bundle counts as consumed and pc takes the target, not the increment.
- Arithmetic: pc+BUNDLE_W is taken modulo 2^72, so it wraps silently. Targets are loaded as given; there is no alignment check.
- At most one request is outstanding. imem_rvalid outside WAIT is ignored.

## Timing
- Reset values:
  - pc=RESET_VECTOR, state=IDLE, squash=0
  - imem_req=0, imem_addr=RESET_VECTOR
  - fetch_valid=0, fetch_bundle=0, fetch_pc=0
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Best-case latency: imem_req in cycle n with gnt in n, rvalid in n+1, fetch_valid in n+2. Next imem_req in n+3 if ready is high in n+2.
- Peak throughput is one bundle per 3 cycles.
- While fetch_valid=1 and fetch_ready=0, fetch_bundle and fetch_pc stay stable.
- Reset asserted mid-operation clears everything immediately (asynchronous). An imem response arriving after reset is ignored.

## Test plan
- Reset then sequential fetch: gnt in the same cycle, rvalid the next, ready held high. Required: imem_addr 0, 120, 240. fetch_pc follows the same sequence. fetch_valid rises 2 cycles after each imem_req.
- Decode stall: hold fetch_ready=0 for 5 cycles in OUT. Required: fetch_bundle and fetch_pc stable, no imem_req. On ready, the next imem_addr is 120 above the stalled bundle's fetch_pc.
- Priority: trap_en, jump_en (0x1234) and branch_en (0x5678) all pulse together in REQ with gnt=0. Required: the next imem_addr is 0x100. Repeat without trap: the next imem_addr is 0x1234.
- Squash: branch_en to 0x3C0 while in WAIT; rvalid returns 0xAAA… two cycles later. Required: fetch_valid stays 0, and the next imem_addr is 0x3C0.
- Redirect coincident with a handshake: fetch_ready=1 and jump_en=1 to 0x78 in OUT. Required: the bundle is accepted once, and the next imem_addr is 0x78, not pc+120.
- Wrap and asynchronous reset: preload pc to 2^72−60 via a jump-free run or force, then complete a handshake. Required: the next pc is 60. Then assert reset mid-WAIT. Required: imem_req=0 and fetch_valid=0 immediately, pc=0, and a late rvalid is ignored.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory request/grant/response plus the
// valid/ready bundle hand-off toward decode.
interface fetch_sequencer_if #(
    parameter int unsigned PC_W     = 72,
    parameter int unsigned BUNDLE_W = 120
);
    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [BUNDLE_W-1:0] imem_rdata;
    logic                fetch_valid;
    logic                fetch_ready;
    logic [BUNDLE_W-1:0] fetch_bundle;
    logic [PC_W-1:0]     fetch_pc;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, fetch_valid, fetch_bundle, fetch_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, fetch_ready
    );

    // Memory/decode side
    modport slave (
        input  imem_req, imem_addr, fetch_valid, fetch_bundle, fetch_pc,
        output imem_gnt, imem_rvalid, imem_rdata, fetch_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one instruction-memory access at a
// time, squashes wrong-path responses and hands bundles to decode.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | just out of reset, redirects ignored, go to REQ next edge
// REQ    | imem_req high at pc, waiting for grant
// WAIT   | request granted, waiting for the response
// OUT    | bundle held for decode until accepted or redirected
module fetch_sequencer #(
    parameter int unsigned     PC_W         = 72,
    parameter int unsigned     BUNDLE_W     = 120,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = 72'h100
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                trap_en_i,
    input  logic                jump_en_i,
    input  logic [54:0]         jump_address_i,
    input  logic                branch_en_i,
    input  logic [67:0]         branch_address_i,
    fetch_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                squash_q, squash_d;
    logic [BUNDLE_W-1:0] bundle_q, bundle_d;
    logic [PC_W-1:0]     bundle_pc_q, bundle_pc_d;

    logic                redirect;
    logic [PC_W-1:0]     target;

    // Redirect resolution, fixed priority trap > jump > branch
    always_comb begin
        redirect = (state_q != S_IDLE) && (trap_en_i || jump_en_i || branch_en_i);
        if (trap_en_i) begin
            target = TRAP_VECTOR;
        end else if (jump_en_i) begin
            target = {{(PC_W-55){1'b0}}, jump_address_i};
        end else begin
            target = {{(PC_W-68){1'b0}}, branch_address_i};
        end
    end

    // Next-state, PC and bundle capture
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        bundle_d    = bundle_q;
        bundle_pc_d = bundle_pc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (bus.imem_gnt) begin
                    state_d = S_WAIT;
                    // the granted access is now wrong-path
                    if (redirect) begin
                        squash_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end
                if (bus.imem_rvalid) begin
                    if (squash_q || redirect) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        bundle_d    = bus.imem_rdata;
                        bundle_pc_d = pc_q;
                        state_d     = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.fetch_ready) begin
                    // a redirect coinciding with acceptance wins over the increment
                    pc_d    = redirect ? target : (pc_q + PC_W'(BUNDLE_W));
                    state_d = S_REQ;
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            squash_q    <= 1'b0;
            bundle_q    <= '0;
            bundle_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            bundle_q    <= bundle_d;
            bundle_pc_q <= bundle_pc_d;
        end
    end

    // Outputs come only from registers or the state decode
    assign bus.imem_req     = (state_q == S_REQ);
    assign bus.imem_addr    = pc_q;
    assign bus.fetch_valid  = (state_q == S_OUT);
    assign bus.fetch_bundle = bundle_q;
    assign bus.fetch_pc     = bundle_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [71:0] WRAP_PC = 72'hFF_FFFF_FFFF_FFFF_FFC4;

    typedef struct packed {
        logic [71:0]  pc;
        logic [119:0] bundle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_en, jump_en, branch_en;
    logic [54:0] jump_address;
    logic [67:0] branch_address;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];

    fetch_sequencer_if #(.PC_W(72), .BUNDLE_W(120)) bus ();
    fetch_sequencer_if #(.PC_W(72), .BUNDLE_W(120)) bus_w ();

    fetch_sequencer dut (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .trap_en_i        (trap_en),
        .jump_en_i        (jump_en),
        .jump_address_i   (jump_address),
        .branch_en_i      (branch_en),
        .branch_address_i (branch_address),
        .bus              (bus)
    );

    fetch_sequencer #(.RESET_VECTOR(WRAP_PC)) dut_w (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .trap_en_i        (1'b0),
        .jump_en_i        (1'b0),
        .jump_address_i   (55'd0),
        .branch_en_i      (1'b0),
        .branch_address_i (68'd0),
        .bus              (bus_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [119:0] rand_bundle();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[119:0];
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b0 || bus.imem_addr !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%0b valid=%0b addr=%0h required 0/0/0",
                     bus.imem_req, bus.fetch_valid, bus.imem_addr);
        end
        n_tests++;
        if (bus.fetch_bundle !== 120'd0 || bus.fetch_pc !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_data: bundle=%0h pc=%0h required 0/0", bus.fetch_bundle, bus.fetch_pc);
        end
        n_tests++;
        if (bus_w.imem_addr !== WRAP_PC) begin
            n_fail++;
            $display("FAIL reset_vector: addr=%0h required %0h", bus_w.imem_addr, WRAP_PC);
        end
        // leave reset with a jump pulse that IDLE must ignore
        rst_n        = 1'b1;
        jump_en      = 1'b1;
        jump_address = 55'h999;
        @(negedge clk);
        jump_en = 1'b0;
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%0b addr=%0h required 1/0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        bit           ok;
        int           t_req;
        logic [119:0] d;
        logic [71:0]  a;
        exp_t         e;
        bus.fetch_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 72'(k * 120);
            wait_req(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL seq_req_timeout: req=%0b required 1", bus.imem_req);
            end
            t_req = cyc;
            n_tests++;
            if (bus.imem_addr !== a) begin
                n_fail++;
                $display("FAIL seq_addr: addr=%0h required %0h", bus.imem_addr, a);
            end
            d = rand_bundle();
            bus.imem_gnt = 1'b1;
            @(negedge clk);
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = d;
            sb_q.push_back({a, d});
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            n_tests++;
            if (bus.fetch_valid !== 1'b1 || (cyc - t_req) != 2) begin
                n_fail++;
                $display("FAIL seq_latency: valid=%0b after %0d cycles required 1 after 2",
                         bus.fetch_valid, cyc - t_req);
            end
            e = sb_q.pop_front();
            n_tests++;
            if (bus.fetch_pc !== e.pc || bus.fetch_bundle !== e.bundle) begin
                n_fail++;
                $display("FAIL seq_bundle: pc=%0h data=%0h required pc=%0h data=%0h",
                         bus.fetch_pc, bus.fetch_bundle, e.pc, e.bundle);
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 72'd360) begin
            n_fail++;
            $display("FAIL seq_next_req: req=%0b addr=%0h required 1/168", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_stall();
        bit           ok;
        logic [119:0] d;
        exp_t         e;
        wait_req(ok);
        n_tests++;
        if (!ok || bus.imem_addr !== 72'd360) begin
            n_fail++;
            $display("FAIL stall_req: req=%0b addr=%0h required 1/168", bus.imem_req, bus.imem_addr);
        end
        d = rand_bundle();
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        bus.fetch_ready = 1'b0;
        sb_q.push_back({72'd360, d});
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = ~d;
        e = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus.fetch_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
                bus.fetch_pc !== e.pc || bus.fetch_bundle !== e.bundle) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%0b req=%0b pc=%0h data=%0h required 1/0 pc=%0h data=%0h",
                         bus.fetch_valid, bus.imem_req, bus.fetch_pc, bus.fetch_bundle, e.pc, e.bundle);
            end
            @(negedge clk);
        end
        bus.fetch_ready = 1'b1;
        e = sb_q.pop_front();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== e.pc || bus.fetch_bundle !== e.bundle) begin
            n_fail++;
            $display("FAIL stall_accept: valid=%0b pc=%0h required 1 pc=%0h", bus.fetch_valid, bus.fetch_pc, e.pc);
        end
        @(negedge clk);
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== e.pc + 72'd120) begin
            n_fail++;
            $display("FAIL stall_next_addr: addr=%0h required %0h", bus.imem_addr, e.pc + 72'd120);
        end
        // a stray response outside WAIT must be ignored
        bus.imem_rvalid = 1'b1;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 72'd480) begin
            n_fail++;
            $display("FAIL stray_rvalid: valid=%0b req=%0b addr=%0h required 0/1/1e0",
                     bus.fetch_valid, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_priority();
        logic [119:0] d;
        exp_t         e;
        trap_en = 1'b1; jump_en = 1'b1; branch_en = 1'b1;
        jump_address = 55'h1234; branch_address = 68'h5678;
        @(negedge clk);
        trap_en = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 72'h100) begin
            n_fail++;
            $display("FAIL prio_trap: addr=%0h required 100", bus.imem_addr);
        end
        jump_en = 1'b1; branch_en = 1'b1;
        @(negedge clk);
        jump_en = 1'b0; branch_en = 1'b0;
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 72'h1234) begin
            n_fail++;
            $display("FAIL prio_jump: addr=%0h required 1234", bus.imem_addr);
        end
        branch_en = 1'b1;
        @(negedge clk);
        branch_en = 1'b0;
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 72'h5678) begin
            n_fail++;
            $display("FAIL prio_branch: addr=%0h required 5678", bus.imem_addr);
        end
        d = rand_bundle();
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        sb_q.push_back({72'h5678, d});
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        e = sb_q.pop_front();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== e.pc || bus.fetch_bundle !== e.bundle) begin
            n_fail++;
            $display("FAIL prio_fetch: valid=%0b pc=%0h required 1 pc=%0h", bus.fetch_valid, bus.fetch_pc, e.pc);
        end
        @(negedge clk);
    endtask

    task automatic test_squash();
        bit           ok;
        logic [119:0] d;
        exp_t         e;
        wait_req(ok);
        n_tests++;
        if (!ok || bus.imem_addr !== 72'h56F0) begin
            n_fail++;
            $display("FAIL squash_req: req=%0b addr=%0h required 1/56f0", bus.imem_req, bus.imem_addr);
        end
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt   = 1'b0;
        branch_en      = 1'b1;
        branch_address = 68'h3C0;
        @(negedge clk);
        branch_en = 1'b0;
        @(negedge clk);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = {30{4'hA}};
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 72'h3C0) begin
            n_fail++;
            $display("FAIL squash_drop: valid=%0b req=%0b addr=%0h required 0/1/3c0",
                     bus.fetch_valid, bus.imem_req, bus.imem_addr);
        end
        d = rand_bundle();
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        sb_q.push_back({72'h3C0, d});
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        e = sb_q.pop_front();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== e.pc || bus.fetch_bundle !== e.bundle) begin
            n_fail++;
            $display("FAIL squash_refetch: valid=%0b pc=%0h data=%0h required 1 pc=%0h data=%0h",
                     bus.fetch_valid, bus.fetch_pc, bus.fetch_bundle, e.pc, e.bundle);
        end
        @(negedge clk);
    endtask

    task automatic test_redirect_handshake();
        bit           ok;
        logic [119:0] d;
        exp_t         e;
        wait_req(ok);
        n_tests++;
        if (!ok || bus.imem_addr !== 72'h438) begin
            n_fail++;
            $display("FAIL rh_req: req=%0b addr=%0h required 1/438", bus.imem_req, bus.imem_addr);
        end
        d = rand_bundle();
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        sb_q.push_back({72'h438, d});
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        e = sb_q.pop_front();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== e.pc || bus.fetch_bundle !== e.bundle) begin
            n_fail++;
            $display("FAIL rh_bundle: valid=%0b pc=%0h required 1 pc=%0h", bus.fetch_valid, bus.fetch_pc, e.pc);
        end
        jump_en      = 1'b1;
        jump_address = 55'h78;
        @(negedge clk);
        jump_en = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 72'h78) begin
            n_fail++;
            $display("FAIL rh_target: valid=%0b req=%0b addr=%0h required 0/1/78",
                     bus.fetch_valid, bus.imem_req, bus.imem_addr);
        end
        // redirect in OUT without ready drops the bundle
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rand_bundle();
        bus.fetch_ready = 1'b0;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 72'h78) begin
            n_fail++;
            $display("FAIL rd_out: valid=%0b pc=%0h required 1/78", bus.fetch_valid, bus.fetch_pc);
        end
        branch_en      = 1'b1;
        branch_address = 68'h500;
        @(negedge clk);
        branch_en = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_addr !== 72'h500) begin
            n_fail++;
            $display("FAIL rd_drop: valid=%0b addr=%0h required 0/500", bus.fetch_valid, bus.imem_addr);
        end
        // redirect coinciding with the response discards it
        bus.fetch_ready = 1'b1;
        bus.imem_gnt    = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        jump_en         = 1'b1;
        jump_address    = 55'h640;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        jump_en         = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 72'h640) begin
            n_fail++;
            $display("FAIL wait_redirect_rvalid: valid=%0b req=%0b addr=%0h required 0/1/640",
                     bus.fetch_valid, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [119:0] d;
        n_tests++;
        if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== WRAP_PC) begin
            n_fail++;
            $display("FAIL wrap_req: req=%0b addr=%0h required 1/%0h", bus_w.imem_req, bus_w.imem_addr, WRAP_PC);
        end
        d = rand_bundle();
        bus_w.fetch_ready = 1'b1;
        bus_w.imem_gnt    = 1'b1;
        @(negedge clk);
        bus_w.imem_gnt    = 1'b0;
        bus_w.imem_rvalid = 1'b1;
        bus_w.imem_rdata  = d;
        @(negedge clk);
        bus_w.imem_rvalid = 1'b0;
        n_tests++;
        if (bus_w.fetch_valid !== 1'b1 || bus_w.fetch_pc !== WRAP_PC || bus_w.fetch_bundle !== d) begin
            n_fail++;
            $display("FAIL wrap_bundle: valid=%0b pc=%0h required 1 pc=%0h", bus_w.fetch_valid, bus_w.fetch_pc, WRAP_PC);
        end
        @(negedge clk);
        n_tests++;
        if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== 72'd60) begin
            n_fail++;
            $display("FAIL wrap_next_pc: addr=%0h required 3c", bus_w.imem_addr);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bus.fetch_ready = 1'b0;
        bus.imem_gnt    = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rand_bundle();
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 72'h640) begin
            n_fail++;
            $display("FAIL areset_setup: valid=%0b pc=%0h required 1/640", bus.fetch_valid, bus.fetch_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 72'd0 ||
            bus.fetch_pc !== 72'd0 || bus.fetch_bundle !== 120'd0) begin
            n_fail++;
            $display("FAIL areset_out: valid=%0b req=%0b addr=%0h pc=%0h required 0/0/0/0",
                     bus.fetch_valid, bus.imem_req, bus.imem_addr, bus.fetch_pc);
        end
        @(negedge clk);
        rst_n           = 1'b1;
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        wait_req(ok);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (!ok || bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b0 || bus.imem_addr !== 72'd0) begin
            n_fail++;
            $display("FAIL areset_wait: req=%0b valid=%0b addr=%0h required 0/0/0",
                     bus.imem_req, bus.fetch_valid, bus.imem_addr);
        end
        @(negedge clk);
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rand_bundle();
        @(negedge clk);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 72'd0) begin
            n_fail++;
            $display("FAIL areset_late_rvalid: valid=%0b req=%0b addr=%0h required 0/1/0",
                     bus.fetch_valid, bus.imem_req, bus.imem_addr);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        trap_en           = 1'b0;
        jump_en           = 1'b0;
        branch_en         = 1'b0;
        jump_address      = '0;
        branch_address    = '0;
        bus.imem_gnt      = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        bus.fetch_ready   = 1'b0;
        bus_w.imem_gnt    = 1'b0;
        bus_w.imem_rvalid = 1'b0;
        bus_w.imem_rdata  = '0;
        bus_w.fetch_ready = 1'b0;

        test_reset();
        test_sequential();
        test_stall();
        test_priority();
        test_squash();
        test_redirect_handshake();
        test_wrap();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
